calc1_port_driver: RTL and testbench
====================================

# calc1_port_driver

Request driver for one calc1 port, placed directly upstream of calc1. It accepts whole operations (command plus two operands) over a valid/ready handshake and serialises each one onto the calc1 two-cycle request protocol. It then waits for the port's response, or a timeout, and returns the result over a second valid/ready handshake. Four instances, one per calc1 port, form the traffic front-end for the calc1 environment.

## Interface
- TIMEOUT_CYCLES, 10, number of WAIT cycles with no response before the operation completes as a timeout (range 1–255)
- c_clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  an operation is offered
- in_ready  output  1  driver can accept an operation
- in_cmd  input  4  calc1 command code
- in_op1  input  32  first operand
- in_op2  input  32  second operand
- req_cmd_out  output  4  to calc1 reqN_cmd_in
- req_data_out  output  32  to calc1 reqN_data_in
- out_resp  input  2  from calc1 out_respN
- out_data  input  32  from calc1 out_dataN
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_resp  output  2  captured response code
- res_data  output  32  captured result data
- res_timeout  output  1  operation ended by timeout

## Operation
- Command codes: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right. All other codes are invalid.
- Response codes: 0 none, 1 success, 2 invalid command / overflow / underflow, 3 unused.
- States: IDLE, OP1, OP2, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, latch cmd/op1/op2.
  - If in_cmd=0, go to DONE with res_resp=2, res_data=0, res_timeout=0. calc1 is not driven.
  - Otherwise go to OP1.
- OP1: req_cmd_out=cmd, req_data_out=op1. Go to OP2.
- OP2: req_cmd_out=0, req_data_out=op2. Clear the timeout counter. Go to WAIT.
- WAIT: req_cmd_out=0, req_data_out=0. Sample out_resp every cycle.
  - On nonzero out_resp: capture out_resp and out_data, set res_timeout=0, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES: res_resp=0, res_data=0, res_timeout=1, go to DONE.
- DONE: res_valid=1 and result held stable. On res_ready, go to IDLE.
- Invalid codes (3, 4, 7–15) are dispatched unchanged. calc1 is expected to answer with resp 2.
- Nonzero out_resp outside WAIT is ignored and never captured.
- req_cmd_out and req_data_out are 0 in every state except OP1 and OP2.

## Timing
- Reset values: in_ready=0 while reset is asserted, then 1 from the first cycle after deassertion. req_cmd_out=0, req_data_out=0, res_valid=0, res_resp=0, res_data=0, res_timeout=0. State is IDLE.
- Accept at edge N. Then:
  - cycle N+1: OP1 is driven.
  - cycle N+2: OP2 is driven.
  - first response sample at edge N+3.
- A response sampled at edge M gives res_valid=1 in cycle M+1.
- A cmd-0 operation gives res_valid=1 in cycle N+1.
- Throughput is one operation in flight. The next accept is possible no earlier than the cycle after the res_valid&res_ready edge.
- A response arriving on the same edge the counter hits TIMEOUT_CYCLES takes priority: it is captured, and res_timeout=0.
- Reset in any state aborts the operation immediately. The pending result is discarded, and calc1 inputs go to 0 asynchronously.
- All outputs are registered.

## Configuration
- CALC1_DRV_TIMEOUT_EN defined: timeout counter present, behaviour as above.
- Not defined: counter removed. WAIT persists until nonzero out_resp, and res_timeout is tied to 0. TIMEOUT_CYCLES is ignored.

## Structure
- Package calc1_pkg holds:
  - command code constants
  - response code constants
  - the driver state encoding
  - the 4-bit command and 32-bit data widths
- One sub-module: calc1_timeout_ctr. It has clear, enable and expiry pulse, is parameterised by TIMEOUT_CYCLES, and is instantiated only under CALC1_DRV_TIMEOUT_EN.

## Test plan
- Add 1 + 0x1FFFFFFF, model calc1 answering resp 1 / 0x20000000 three cycles after OP2 → res_valid with res_resp=1, res_data=0x20000000, res_timeout=0; OP1 cycle shows cmd 1 / data 1, OP2 cycle shows cmd 0 / data 0x1FFFFFFF.
- Subtract 1 − 2, model answers resp 2 → res_resp=2 captured, res_timeout=0.
- out_resp held 0 after dispatch (macro defined, TIMEOUT_CYCLES=10) → res_timeout=1, res_resp=0, res_data=0, res_valid in the cycle after the 10th WAIT edge.
- cmd 0 offered → res_valid next cycle with res_resp=2; req_cmd_out and req_data_out stay 0 throughout.
- res_ready held low 5 cycles in DONE → result stable, in_ready=0, a second offered operation is not accepted until the handshake completes.
- reset pulsed during WAIT, then a response pulse → no res_valid, all outputs 0, in_ready=1 from the first cycle after reset deasserts.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1 driver shared definitions: command/response codes, state encoding, widths.
package calc1_pkg;

  localparam int CMD_W  = 4;
  localparam int DATA_W = 32;
  localparam int RESP_W = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE   = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK     = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR    = 2'd2;
  localparam logic [RESP_W-1:0] RESP_UNUSED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP1  = 3'd1,
    ST_OP2  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } drv_state_e;

endpackage

// File: rtl/calc1_timeout_ctr.sv
// WAIT-cycle counter for the calc1 port driver. expire pulses on the enabled
// cycle that would bring the count to TIMEOUT_CYCLES.
import calc1_pkg::*;

module calc1_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic c_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] cnt;

  // Count enabled cycles; clear wins over enable.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset)       cnt <= 8'd0;
    else if (clear)  cnt <= 8'd0;
    else if (enable) cnt <= cnt + 8'd1;
  end

  assign expire = enable && !clear && (cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc1_port_driver.sv
// Request driver for one calc1 port: accepts cmd+op1+op2, serialises onto the
// two-cycle calc1 request protocol, waits for a response and returns it.
// Build option: CALC1_DRV_TIMEOUT_EN enables the WAIT timeout counter; without
// it WAIT persists until a nonzero response and res_timeout stays 0.
import calc1_pkg::*;

module calc1_port_driver #(
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  output logic [CMD_W-1:0]  req_cmd_out,
  output logic [DATA_W-1:0] req_data_out,
  input  logic [RESP_W-1:0] out_resp,
  input  logic [DATA_W-1:0] out_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RESP_W-1:0] res_resp,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout
);

  drv_state_e        state_q, state_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [CMD_W-1:0]  req_cmd_d;
  logic [DATA_W-1:0] req_data_d;
  logic [RESP_W-1:0] res_resp_d;
  logic [DATA_W-1:0] res_data_d;
  logic              res_to_d;
  logic              timeout_hit;

`ifdef CALC1_DRV_TIMEOUT_EN
  logic to_clear, to_en;

  // Counter restarts in OP2 and advances on every response-less WAIT cycle.
  assign to_clear = (state_q == ST_OP2);
  assign to_en    = (state_q == ST_WAIT) && (out_resp == RESP_NONE);

  calc1_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout_ctr (
    .c_clk  (c_clk),
    .reset  (reset),
    .clear  (to_clear),
    .enable (to_en),
    .expire (timeout_hit)
  );
`else
  // TIMEOUT_CYCLES has no effect in this build.
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    op2_d      = op2_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    res_resp_d = res_resp;
    res_data_d = res_data;
    res_to_d   = res_timeout;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op2_d = in_op2;
          if (in_cmd == CMD_NOP) begin
            // No-op never reaches calc1; answer locally with an error code.
            state_d    = ST_DONE;
            res_resp_d = RESP_ERR;
            res_data_d = '0;
            res_to_d   = 1'b0;
          end else begin
            state_d    = ST_OP1;
            req_cmd_d  = in_cmd;
            req_data_d = in_op1;
          end
        end
      end
      ST_OP1: begin
        state_d    = ST_OP2;
        req_data_d = op2_q;
      end
      ST_OP2: state_d = ST_WAIT;
      ST_WAIT: begin
        // A response on the expiry cycle takes priority over the timeout.
        if (out_resp != RESP_NONE) begin
          state_d    = ST_DONE;
          res_resp_d = out_resp;
          res_data_d = out_data;
          res_to_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d    = ST_DONE;
          res_resp_d = RESP_NONE;
          res_data_d = '0;
          res_to_d   = 1'b1;
        end
      end
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op2_q        <= '0;
      in_ready     <= 1'b0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      res_valid    <= 1'b0;
      res_resp     <= '0;
      res_data     <= '0;
      res_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op2_q        <= op2_d;
      in_ready     <= (state_d == ST_IDLE);
      req_cmd_out  <= req_cmd_d;
      req_data_out <= req_data_d;
      res_valid    <= (state_d == ST_DONE);
      res_resp     <= res_resp_d;
      res_data     <= res_data_d;
      res_timeout  <= res_to_d;
    end
  end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver; the bench drives out_resp as the calc1 model.
module tb_calc1_port_driver;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic        res_timeout;

  int checks = 0;
  int errors = 0;

  calc1_port_driver #(.TIMEOUT_CYCLES(10)) dut (
    .c_clk(c_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp(out_resp), .out_data(out_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_resp(res_resp), .res_data(res_data), .res_timeout(res_timeout)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_cmd = c; in_op1 = a; in_op2 = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    checks++; if ({req_cmd_out, req_data_out} !== 36'd0) begin errors++; $display("FAIL rst_req: got %h %h exp 0", req_cmd_out, req_data_out); end
    checks++; if ({res_valid, res_resp, res_data, res_timeout} !== 36'd0) begin errors++; $display("FAIL rst_res: got %b %h %h %b exp 0", res_valid, res_resp, res_data, res_timeout); end
    reset = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    accept(4'd1, 32'd1, 32'h1FFF_FFFF);
    checks++; if (req_cmd_out !== 4'd1 || req_data_out !== 32'd1) begin errors++; $display("FAIL add_op1: got %h %h exp 1 1", req_cmd_out, req_data_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_busy: got %b exp 0", in_ready); end
    tick();
    checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'h1FFF_FFFF) begin errors++; $display("FAIL add_op2: got %h %h exp 0 1fffffff", req_cmd_out, req_data_out); end
    tick();
    checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0) begin errors++; $display("FAIL add_wait_req: got %h %h exp 0 0", req_cmd_out, req_data_out); end
    tick(); tick();
    out_resp = 2'd1; out_data = 32'h2000_0000;
    tick();
    out_resp = 2'd0; out_data = 32'd0;
    checks++; if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'd1, 32'h2000_0000, 1'b0}) begin errors++; $display("FAIL add_result: got %b %h %h %b exp 1 1 20000000 0", res_valid, res_resp, res_data, res_timeout); end
    handshake();
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_release: got v=%b r=%b exp v=0 r=1", res_valid, in_ready); end
  endtask

  task automatic test_sub_ignore();
    accept(4'd2, 32'd1, 32'd2);
    // Responses during OP1/OP2 must not be captured.
    out_resp = 2'd3; out_data = 32'h55;
    tick(); tick();
    out_resp = 2'd0; out_data = 32'd0;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL sub_early_resp: got %b exp 0", res_valid); end
    out_resp = 2'd2; out_data = 32'hDEAD;
    tick();
    out_resp = 2'd0; out_data = 32'd0;
    checks++; if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'd2, 32'hDEAD, 1'b0}) begin errors++; $display("FAIL sub_result: got %b %h %h %b exp 1 2 dead 0", res_valid, res_resp, res_data, res_timeout); end
    handshake();
  endtask

  task automatic test_timeout();
    accept(4'd1, 32'd5, 32'd6);
    tick(); tick();
`ifdef CALC1_DRV_TIMEOUT_EN
    for (int i = 0; i < 9; i++) tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL to_early: got %b exp 0", res_valid); end
    tick();
    checks++; if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'd0, 32'd0, 1'b1}) begin errors++; $display("FAIL to_result: got %b %h %h %b exp 1 0 0 1", res_valid, res_resp, res_data, res_timeout); end
`else
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin tick(); if (res_valid) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL nto_wait: got %0d valid cycles exp 0", seen); end
    end
    out_resp = 2'd1; out_data = 32'd7;
    tick();
    out_resp = 2'd0; out_data = 32'd0;
    checks++; if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'd1, 32'd7, 1'b0}) begin errors++; $display("FAIL nto_result: got %b %h %h %b exp 1 1 7 0", res_valid, res_resp, res_data, res_timeout); end
`endif
    handshake();
  endtask

  task automatic test_nop();
    int req_seen = 0;
    accept(4'd0, 32'hAAAA, 32'hBBBB);
    checks++; if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'd2, 32'd0, 1'b0}) begin errors++; $display("FAIL nop_result: got %b %h %h %b exp 1 2 0 0", res_valid, res_resp, res_data, res_timeout); end
    for (int i = 0; i < 3; i++) begin
      if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0) req_seen++;
      tick();
    end
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL nop_req_quiet: got %0d driven cycles exp 0", req_seen); end
    handshake();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    accept(4'd5, 32'd3, 32'd1);
    tick(); tick();
    out_resp = 2'd1; out_data = 32'h18;
    tick();
    out_resp = 2'd0; out_data = 32'd0;
    in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'h77; in_op2 = 32'h88;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_resp !== 2'd1 || res_data !== 32'h18 || in_ready !== 1'b0 || req_cmd_out !== 4'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles exp 0", bad); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || req_cmd_out !== 4'd0) begin errors++; $display("FAIL bp_release: got v=%b r=%b cmd=%h exp 0 1 0", res_valid, in_ready, req_cmd_out); end
    tick();
    in_valid = 1'b0;
    checks++; if (req_cmd_out !== 4'd1 || req_data_out !== 32'h77) begin errors++; $display("FAIL bp_next_accept: got %h %h exp 1 77", req_cmd_out, req_data_out); end
    tick(); tick();
    out_resp = 2'd1; out_data = 32'hFF;
    tick();
    out_resp = 2'd0; out_data = 32'd0;
    checks++; if (res_valid !== 1'b1 || res_data !== 32'hFF) begin errors++; $display("FAIL bp_second: got %b %h exp 1 ff", res_valid, res_data); end
    handshake();
  endtask

  task automatic test_reset_wait();
    accept(4'd1, 32'd1, 32'd1);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if ({in_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout} !== 72'd0) begin errors++; $display("FAIL rw_async: got r=%b %h %h v=%b %h %h %b exp 0", in_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout); end
    tick();
    reset = 1'b0;
    out_resp = 2'd1; out_data = 32'd99;
    tick();
    out_resp = 2'd0; out_data = 32'd0;
    checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_resp !== 2'd0 || res_data !== 32'd0) begin errors++; $display("FAIL rw_after: got r=%b v=%b %h %h exp 1 0 0 0", in_ready, res_valid, res_resp, res_data); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rw_no_result: got %b exp 0", res_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ignore();
    test_timeout();
    test_nop();
    test_backpressure();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
